// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state type and
// request/response slot width helpers reused by the top and its users.
package bus_arbiter_rr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Request slot layout, MSB first: {valid, address, wdata, wstrb}.
    function automatic int unsigned req_width(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response slot layout, MSB first: {rdata, ready}.
    function automatic int unsigned resp_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_prio_enc.sv
// Rotating-priority search: first set bit of req at or above ptr, wrapping
// from N-1 back to 0. Purely combinational.
module rr_prio_enc #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Two-state round-robin arbiter sharing one slave among N_MASTERS masters;
// the winner is registered in IDLE and owns the slave until ready or abort.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter  int unsigned N_MASTERS = 2,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned DATA_W    = 32,
    localparam int unsigned REQ_W     = req_width(ADDR_W, DATA_W),
    localparam int unsigned RESP_W    = resp_width(DATA_W),
    localparam int unsigned GNT_W     = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [GNT_W-1:0]              grant,
    output logic                          busy
);

    logic [N_MASTERS-1:0][REQ_W-1:0]  slot;
    logic [N_MASTERS-1:0][RESP_W-1:0] resp;
    logic [N_MASTERS-1:0]             valid;

    arb_state_e       state_q, state_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [GNT_W-1:0] ptr_q, ptr_d;
    logic [GNT_W-1:0] win_idx, ptr_next;
    logic             win_any;

    assign slot   = m_req;
    assign m_resp = resp;
    assign grant  = grant_q;
    assign busy   = (state_q == ST_BUSY);

    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            valid[i] = slot[i][REQ_W-1];
        end
    end

    rr_prio_enc #(
        .N     (N_MASTERS),
        .IDX_W (GNT_W)
    ) u_prio (
        .req (valid),
        .ptr (ptr_q),
        .idx (win_idx),
        .any (win_any)
    );

    // Explicit wrap keeps ptr in range for non-power-of-two master counts.
    assign ptr_next = (grant_q == GNT_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_BUSY;
                    grant_d = win_idx;
                end
            end
            ST_BUSY: begin
                // Completion (ready) and abort (owner dropped valid) retire alike.
                if (s_resp[0] || !valid[grant_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        s_req = '0;
        resp  = '0;
        if (state_q == ST_BUSY) begin
            s_req         = slot[grant_q];
            resp[grant_q] = s_resp;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr with four masters: reset checks, a
// vector table, directed corner sequences and randomized traffic vs a model.
module tb_bus_arbiter_rr;

    localparam int N      = 4;
    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic                  clk;
    logic                  rst;
    logic [N*REQ_W-1:0]    m_req;
    logic [N*RESP_W-1:0]   m_resp;
    logic [REQ_W-1:0]      s_req;
    logic [RESP_W-1:0]     s_resp;
    logic [1:0]            grant;
    logic                  busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: owner flag, owning master, search start.
    bit mb;
    int mg;
    int mp;

    typedef struct {
        logic [3:0] vmask;
        logic       rdy;
        logic       exp_busy;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t tbl[10];

    bus_arbiter_rr #(
        .N_MASTERS (N),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp),
        .grant  (grant),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic mvalid(input int i);
        return m_req[i*REQ_W + REQ_W - 1];
    endfunction

    function automatic logic [RESP_W-1:0] resp_of(input int i);
        return m_resp[i*RESP_W +: RESP_W];
    endfunction

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        m_req[i*REQ_W +: REQ_W] = {v, a, d, s};
    endtask

    task automatic set_mask(input logic [3:0] vm);
        for (int i = 0; i < N; i++)
            set_req(i, vm[i], 32'h1000_0000 + i, 32'h0000_00A0 + i, 4'hF);
    endtask

    task automatic model_reset();
        mb = 0;
        mg = 0;
        mp = 0;
    endtask

    task automatic model_step();
        bit found;
        found = 0;
        if (!mb) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mp + k) % N;
                if (!found && mvalid(j)) begin
                    found = 1;
                    mg = j;
                end
            end
            if (found) mb = 1;
        end else if (s_resp[0] || !mvalid(mg)) begin
            mb = 0;
            mp = (mg + 1) % N;
        end
    endtask

    task automatic check_model(input string tag);
        logic [REQ_W-1:0]    es;
        logic [N*RESP_W-1:0] er;
        es = '0;
        er = '0;
        if (mb) begin
            es = m_req[mg*REQ_W +: REQ_W];
            er[mg*RESP_W +: RESP_W] = s_resp;
        end
        check({tag, "_busy"}, busy, mb);
        check({tag, "_grant"}, grant, mg[1:0]);
        check({tag, "_sreq"}, s_req, es);
        check({tag, "_mresp"}, m_resp, er);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // all masters requesting, single-cycle slave: 0,1,2,3,0 every 2 cycles
        tbl[0] = '{4'hF, 1'b1, 1'b1, 2'd0};
        tbl[1] = '{4'hF, 1'b1, 1'b0, 2'd0};
        tbl[2] = '{4'hF, 1'b1, 1'b1, 2'd1};
        tbl[3] = '{4'hF, 1'b1, 1'b0, 2'd1};
        tbl[4] = '{4'hF, 1'b1, 1'b1, 2'd2};
        tbl[5] = '{4'hF, 1'b1, 1'b0, 2'd2};
        tbl[6] = '{4'hF, 1'b1, 1'b1, 2'd3};
        tbl[7] = '{4'hF, 1'b1, 1'b0, 2'd3};
        tbl[8] = '{4'hF, 1'b1, 1'b1, 2'd0};
        tbl[9] = '{4'hF, 1'b1, 1'b0, 2'd0};

        rst    = 1'b0;
        m_req  = '0;
        s_resp = '0;
        model_reset();

        // reset holds everything quiet, even with requests and a ready slave
        set_mask(4'hF);
        s_resp = {32'hCAFE_F00D, 1'b1};
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 2'd0);
        check("rst_sreq", s_req, '0);
        check("rst_mresp", m_resp, '0);
        @(posedge clk);
        #1;
        check("rst_clk_busy", busy, 1'b0);
        check("rst_clk_mresp", m_resp, '0);

        // vector table
        set_mask(4'h0);
        do_reset();
        for (int r = 0; r < 10; r++) begin
            set_mask(tbl[r].vmask);
            s_resp = {32'h5000 + r, tbl[r].rdy};
            tick();
            check($sformatf("tbl%0d_busy", r), busy, tbl[r].exp_busy);
            check($sformatf("tbl%0d_grant", r), grant, tbl[r].exp_grant);
        end

        // only m2 valid, ready on the third BUSY cycle
        set_mask(4'h0);
        s_resp = '0;
        do_reset();
        set_req(2, 1'b1, 32'h0000_2200, 32'h1234_5678, 4'hA);
        tick();
        check("m2_busy", busy, 1'b1);
        check("m2_grant", grant, 2'd2);
        check("m2_sreq", s_req, {1'b1, 32'h0000_2200, 32'h1234_5678, 4'hA});
        tick();
        tick();
        s_resp = {32'hDEAD_BEEF, 1'b1};
        #1;
        check("m2_resp", resp_of(2), {32'hDEAD_BEEF, 1'b1});
        check("m2_resp_m0", resp_of(0), '0);
        tick();
        check("m2_done_busy", busy, 1'b0);
        s_resp = '0;
        set_mask(4'b1001);
        tick();
        check("m2_ptr3_grant", grant, 2'd3);

        // ptr=3 with masters 0 and 1 valid wraps to 0, then ptr=1
        set_mask(4'h0);
        do_reset();
        set_mask(4'b0100);
        tick();
        s_resp = {32'h0, 1'b1};
        tick();
        s_resp = '0;
        set_mask(4'b0011);
        tick();
        check("wrap_grant", grant, 2'd0);
        s_resp = {32'h0, 1'b1};
        tick();
        s_resp = '0;
        tick();
        check("wrap_ptr1_grant", grant, 2'd1);

        // m0 requests while m1 owns the slave
        set_mask(4'h0);
        s_resp = '0;
        do_reset();
        set_mask(4'b0010);
        tick();
        set_mask(4'b0011);
        s_resp = {32'h0000_0011, 1'b0};
        tick();
        check("hold_grant", grant, 2'd1);
        check("hold_busy", busy, 1'b1);
        check("hold_m0_resp", resp_of(0), '0);
        s_resp = {32'h0000_0022, 1'b1};
        #1;
        check("hold_m1_resp", resp_of(1), {32'h0000_0022, 1'b1});
        check("hold_m0_noready", resp_of(0), '0);
        tick();
        set_mask(4'b0001);
        s_resp = '0;
        tick();
        check("hold_next_grant", grant, 2'd0);

        // async reset in BUSY with m3 granted
        set_mask(4'h0);
        do_reset();
        set_mask(4'b1000);
        tick();
        s_resp = {32'h1234_5678, 1'b0};
        #1;
        check("arst_pre_resp", resp_of(3), {32'h1234_5678, 1'b0});
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_grant", grant, 2'd0);
        check("arst_sreq", s_req, '0);
        check("arst_mresp", m_resp, '0);
        #1;
        rst = 1'b1;
        tick();
        check("arst_regrant", grant, 2'd3);
        check("arst_rebusy", busy, 1'b1);

        // granted m2 drops valid before ready: abort, ptr=3
        set_mask(4'h0);
        s_resp = '0;
        do_reset();
        set_mask(4'b0100);
        tick();
        set_mask(4'b0000);
        s_resp = {32'h0000_7777, 1'b0};
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("abort_noready%0d", i), resp_of(i) & 33'h1, '0);
        tick();
        check("abort_busy", busy, 1'b0);
        s_resp = '0;
        set_mask(4'b1001);
        tick();
        check("abort_ptr3_grant", grant, 2'd3);

        // randomized traffic against the model
        set_mask(4'h0);
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                check_model("rnd_rst");
            end
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom));
            s_resp = {32'($urandom), ($urandom_range(0, 2) == 0)};
            #1;
            check_model("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter N_MASTERS, default 2, SHALL set the number of requesting masters (2..16).
REQ-002 Parameter ADDR_W, default 32, SHALL set the request address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the rdata/wdata width; wstrb width SHALL be DATA_W/8.
REQ-004 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low (0 = reset).
REQ-006 Port m_req, input, N_MASTERS*REQ_W: concatenated master requests; slot i at [(i+1)*REQ_W-1 : i*REQ_W].
REQ-007 Each request slot SHALL be laid out as {valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}, MSB first.
REQ-008 Each request SHALL be REQ_W = 1+ADDR_W+DATA_W+DATA_W/8 bits wide.
REQ-009 Port m_resp, output, N_MASTERS*RESP_W: concatenated master responses, {rdata[DATA_W], ready}, with RESP_W = DATA_W+1.
REQ-010 Port s_req, output, REQ_W: request to the shared slave.
REQ-011 Port s_resp, input, RESP_W: response from the shared slave.
REQ-012 Port grant, output, clog2(N_MASTERS): index of the owning master.
REQ-013 Port busy, output, 1: high while a transaction owns the slave.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-015 In IDLE with any master valid=1, the FSM SHALL latch the winner into grant and enter BUSY on the next edge, giving one cycle of arbitration latency.
REQ-016 The winner SHALL be the first master with valid=1, searching upward from pointer ptr and wrapping from N_MASTERS-1 to 0.
REQ-017 In IDLE with no master valid, the FSM SHALL remain in IDLE and keep grant and ptr unchanged.
REQ-018 In BUSY, s_req SHALL equal the granted master's request slot combinationally.
REQ-019 In IDLE, s_req SHALL be all zeros.
REQ-020 The granted master's m_resp SHALL equal s_resp.
REQ-021 Every other master's m_resp SHALL be all zeros (ready=0, rdata=0).
REQ-022 In BUSY, s_resp.ready=1 SHALL complete the transaction: the FSM enters IDLE and sets ptr to (grant+1) mod N_MASTERS.
REQ-023 Ready in the first BUSY cycle SHALL be valid, so the minimum transaction length is 1 BUSY cycle.
REQ-024 The next arbitration SHALL take place in the IDLE cycle that follows completion, giving back-to-back grants every 2 cycles for single-cycle slaves.
REQ-025 In BUSY, if the granted master's valid=0 and ready=0, the transaction SHALL be aborted: the FSM enters IDLE and ptr advances as in REQ-022.
REQ-026 Valid from non-granted masters during BUSY SHALL be ignored and SHALL NOT disturb grant.
REQ-027 Masters SHALL hold valid and their request fields stable until they see ready.
REQ-028 busy SHALL be 1 exactly when the state is BUSY.
REQ-029 ptr and grant SHALL wrap modulo N_MASTERS; values >= N_MASTERS SHALL be unreachable.

Reset
REQ-030 While rst=0, the state SHALL be IDLE and grant=0, ptr=0, busy=0, and s_req=0.
REQ-031 While rst=0, all m_resp slots SHALL be 0, independent of clk.
REQ-032 Reset asserted mid-BUSY SHALL abort the transaction immediately, with no completion reported to any master.
REQ-033 Arbitration SHALL resume on the first rising edge after rst returns to 1.

Structure
REQ-034 REQ_W/RESP_W width macros and field-slice macros SHALL live in the shared interconnect header and be reused unchanged from the split/merge blocks.
REQ-035 The rotating-priority search SHALL be one sub-module, rr_prio_enc, with inputs req[N], ptr and outputs idx and any.
REQ-036 rr_prio_enc SHALL be purely combinational.

Verification
REQ-037 N=4, only m2 valid from IDLE -> grant=2 and busy=1 one cycle later; slave ready after 3 cycles -> m2 ready=1 with rdata=0xDEADBEEF; ptr=3.
REQ-038 N=4, all masters valid continuously, single-cycle slave -> grant sequence 0,1,2,3,0 with a grant every 2 cycles.
REQ-039 ptr=3, masters 0 and 1 valid -> grant=0 (wrap-around); ptr=1 after completion.
REQ-040 m1 granted, m0 raises valid mid-transaction -> grant stays 1; m0 sees ready=0 until m1 completes; m0 is granted next.
REQ-041 rst pulled low in BUSY with m3 granted -> busy=0, s_req=0, all m_resp=0 asynchronously; after release with m3 still valid -> grant=0 search yields 3.
REQ-042 Granted m2 drops valid before ready -> IDLE on the next edge, ptr=3, no ready to any master.
